// File: rtl/ifid_queue_if.sv
// Handshake bundle between fetch, the IF/ID queue and decode.
// The queue takes the slave modport; the fetch/decode side (or a bench) takes master.
interface ifid_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  if_valid;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_PC;
  logic [DATA_WIDTH-1:0] if_pc_plus_4;
  logic [DATA_WIDTH-1:0] if_instruction;
  logic                  if_pred;
  logic [DATA_WIDTH-1:0] if_pred_PC_target;
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_PC;
  logic [DATA_WIDTH-1:0] id_pc_plus_4;
  logic [DATA_WIDTH-1:0] id_instruction;
  logic                  id_pred;
  logic [DATA_WIDTH-1:0] id_pred_PC_target;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, if_valid, if_PC, if_pc_plus_4, if_instruction, if_pred,
           if_pred_PC_target, id_ready,
    input  if_ready, id_valid, id_PC, id_pc_plus_4, id_instruction, id_pred,
           id_pred_PC_target, count
  );

  modport slave (
    input  flush, if_valid, if_PC, if_pc_plus_4, if_instruction, if_pred,
           if_pred_PC_target, id_ready,
    output if_ready, id_valid, id_PC, id_pc_plus_4, id_instruction, id_pred,
           id_pred_PC_target, count
  );
endinterface

// File: rtl/ifid_queue.sv
// DEPTH-entry IF/ID FIFO with valid/ready on both sides and single-cycle flush.
// Define IFID_QUEUE_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module ifid_queue #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         rstn,
  ifid_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus_4;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  pred;
    logic [DATA_WIDTH-1:0] target;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head_entry;
  entry_t           out_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             bypass_take;
  logic             push;
  logic             pop;
  logic             id_valid_int;

  assign in_entry = '{pc:          q.if_PC,
                      pc_plus_4:   q.if_pc_plus_4,
                      instruction: q.if_instruction,
                      pred:        q.if_pred,
                      target:      q.if_pred_PC_target};

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

`ifdef IFID_QUEUE_BYPASS_EN
  assign bypass = empty & q.if_valid & ~q.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed this cycle never touches storage.
  assign bypass_take = bypass & q.id_ready;
  assign push        = q.if_valid & ~full & ~bypass_take;
  assign pop         = ~empty & q.id_ready;

  always_comb begin
    head_entry   = mem[head];
    id_valid_int = ~empty;
    if (bypass) begin
      head_entry   = in_entry;
      id_valid_int = 1'b1;
    end
    out_entry = id_valid_int ? head_entry : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset; only entries between head and tail are ever presented.
  always_ff @(posedge clk) begin
    if (push && !q.flush) mem[tail] <= in_entry;
  end

  assign q.if_ready          = ~full;
  assign q.id_valid          = id_valid_int;
  assign q.id_PC             = out_entry.pc;
  assign q.id_pc_plus_4      = out_entry.pc_plus_4;
  assign q.id_instruction    = out_entry.instruction;
  assign q.id_pred           = out_entry.pred;
  assign q.id_pred_PC_target = out_entry.target;
  assign q.count             = cnt;
endmodule

// File: tb/tb_ifid_queue.sv
// Randomized bench for ifid_queue against a queue-based model of the fetch/decode FIFO.
// Honours IFID_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_ifid_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef IFID_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc_plus_4;
    logic [DW-1:0] instruction;
    logic          pred;
    logic [DW-1:0] target;
  } entry_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  ifid_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ifid_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .q    (bus)
  );

  always #5 clk = ~clk;

  entry_t model[$];
  entry_t curIn;
  int     vectorCount = 0;
  int     missCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    entry_t exp;
    bit     expValid;
    exp      = '0;
    expValid = (model.size() != 0) || (BYPASS && bus.if_valid && !bus.flush);
    if (model.size() != 0) exp = model[0];
    else if (expValid)     exp = curIn;
    checkOutput("id_valid",          64'(bus.id_valid),          64'(expValid));
    checkOutput("id_PC",             64'(bus.id_PC),             64'(exp.pc));
    checkOutput("id_pc_plus_4",      64'(bus.id_pc_plus_4),      64'(exp.pc_plus_4));
    checkOutput("id_instruction",    64'(bus.id_instruction),    64'(exp.instruction));
    checkOutput("id_pred",           64'(bus.id_pred),           64'(exp.pred));
    checkOutput("id_pred_PC_target", 64'(bus.id_pred_PC_target), 64'(exp.target));
    checkOutput("if_ready",          64'(bus.if_ready),          64'(model.size() < DEPTH));
    checkOutput("count",             64'(bus.count),             64'(model.size()));
  endtask

  // One clock: drive at the falling edge, check just after, then commit the model at the rising edge.
  task automatic applyStimulus(input bit valid, input logic [DW-1:0] pc, input bit ready, input bit flush);
    bit takeNow;
    bit doPop;
    bit doPush;
    @(negedge clk);
    curIn.pc          = pc;
    curIn.pc_plus_4   = pc + 32'd4;
    curIn.instruction = $urandom;
    curIn.pred        = 1'($urandom_range(0, 1));
    curIn.target      = $urandom;
    bus.if_valid          = valid;
    bus.if_PC             = curIn.pc;
    bus.if_pc_plus_4      = curIn.pc_plus_4;
    bus.if_instruction    = curIn.instruction;
    bus.if_pred           = curIn.pred;
    bus.if_pred_PC_target = curIn.target;
    bus.id_ready          = ready;
    bus.flush             = flush;
    #1 checkModel();
    if (flush) begin
      model.delete();
    end else begin
      takeNow = BYPASS && (model.size() == 0) && valid && ready;
      doPop   = (model.size() != 0) && ready;
      doPush  = valid && (model.size() < DEPTH) && !takeNow;
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(curIn);
    end
    @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] pc;
    curIn                 = '0;
    bus.flush             = 1'b0;
    bus.if_valid          = 1'b0;
    bus.if_PC             = '0;
    bus.if_pc_plus_4      = '0;
    bus.if_instruction    = '0;
    bus.if_pred           = 1'b0;
    bus.if_pred_PC_target = '0;
    bus.id_ready          = 1'b0;

    #12;
    checkModel();
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill while decode stalls, then try a fifth push.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Hold two entries and stream through across the pointer wrap.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(32'h28 + i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with three entries while fetch presents 0x40.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h30 + i * 4), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Empty queue, decode ready: bypass build forwards 0x80 immediately.
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in mid-operation.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h90 + i * 4), 1'b0, 1'b0);
    @(negedge clk);
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b0;
    bus.flush    = 1'b0;
    #2 rstn = 1'b0;
    model.delete();
    #1 checkModel();
    @(negedge clk);
    rstn = 1'b1;

    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit r;
      bit f;
      v = ($urandom_range(0, 3) != 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 31) == 0);
      applyStimulus(v, pc, r, f);
      pc = pc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
